// File: rtl/mix_columns_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_unit_if
// Purpose  : Start/ready handshake and 128-bit state bus of the MixColumns stage.
//            inv_in exists only when MC_INV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mix_columns_unit_if #(
    parameter int DATA_W = 128
);
    logic              start_in;
    logic [DATA_W-1:0] data_in;
`ifdef MC_INV_EN
    logic              inv_in;
`endif
    logic              ready_out;
    logic              busy_out;
    logic [DATA_W-1:0] data_out;

`ifdef MC_INV_EN
    modport master (output start_in, data_in, inv_in, input ready_out, busy_out, data_out);
    modport slave  (input start_in, data_in, inv_in, output ready_out, busy_out, data_out);
`else
    modport master (output start_in, data_in, input ready_out, busy_out, data_out);
    modport slave  (input start_in, data_in, output ready_out, busy_out, data_out);
`endif
endinterface
`default_nettype wire

// File: rtl/mix_columns_unit.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_unit
// Purpose  : AES MixColumns stage, one 32-bit column per clock through a single
//            shared mixer. Define MC_INV_EN to add InvMixColumns via inv_in.
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_unit #(
    parameter int NUM_COLS = 4,
    parameter int COL_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    mix_columns_unit_if.slave bus
);

    localparam int c_DATA_W = NUM_COLS * COL_W;
    localparam int c_CNT_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_COL = c_CNT_W'(NUM_COLS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;
    logic [c_CNT_W-1:0]   r_col_cnt;
    logic [c_DATA_W-1:0]  r_cap;
    logic [c_DATA_W-1:0]  r_data_out;
    logic                 r_ready;
    logic                 r_busy;
    logic [COL_W-1:0]     w_cols [NUM_COLS];
    logic [COL_W-1:0]     w_col_sel;
    logic [COL_W-1:0]     w_mixed;
`ifdef MC_INV_EN
    logic                 r_inv;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        // 3*b is xtime(b)^b, so each row is two doubled bytes plus three plain ones
        return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                a0 ^ d1 ^ d2 ^ a2 ^ a3,
                a0 ^ a1 ^ d2 ^ d3 ^ a3,
                d0 ^ a0 ^ a1 ^ a2 ^ d3};
    endfunction

`ifdef MC_INV_EN
    // Returns {0E*b, 0B*b, 0D*b, 09*b} built from one xtime chain
    function automatic logic [31:0] inv_mults(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [31:0] p0, p1, p2, p3;
        p0 = inv_mults(col[31:24]);
        p1 = inv_mults(col[23:16]);
        p2 = inv_mults(col[15:8]);
        p3 = inv_mults(col[7:0]);
        return {p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
                p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
                p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
                p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24]};
    endfunction
`endif

    generate
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_unpack
            assign w_cols[c] = r_cap[c_DATA_W-1-COL_W*c -: COL_W];
        end
    endgenerate

    assign w_col_sel = w_cols[r_col_cnt];

    always_comb begin
`ifdef MC_INV_EN
        w_mixed = r_inv ? mix_inv(w_col_sel) : mix_fwd(w_col_sel);
`else
        w_mixed = mix_fwd(w_col_sel);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_in) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_col_cnt == c_LAST_COL) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt  <= '0;
            r_cap      <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
`ifdef MC_INV_EN
            r_inv      <= 1'b0;
`endif
        end else begin
            r_ready <= w_last;
            if (w_accept) begin
                r_cap     <= bus.data_in;
                r_col_cnt <= '0;
                r_busy    <= 1'b1;
`ifdef MC_INV_EN
                r_inv     <= bus.inv_in;
`endif
            end
            if (r_state == ST_CALC) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (r_col_cnt == c_CNT_W'(c)) begin
                        r_data_out[c_DATA_W-1-COL_W*c -: COL_W] <= w_mixed;
                    end
                end
                r_col_cnt <= w_last ? '0 : r_col_cnt + c_CNT_W'(1);
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign bus.ready_out = r_ready;
    assign bus.busy_out  = r_busy;
    assign bus.data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_unit
// Purpose  : Self-checking bench for mix_columns_unit against a GF(2^8) matrix
//            model; inverse-mode vectors run when MC_INV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    localparam logic [127:0] c_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] c_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] c_FIPS_IN  = 128'hd4bf5d30_00000000_00000000_00000000;
    localparam logic [127:0] c_FIPS_OUT = 128'h046681e5_00000000_00000000_00000000;
    localparam logic [127:0] c_INV_IN  = 128'h046681e5_8e4da1bc_00000000_01010101;
    localparam logic [127:0] c_INV_OUT = 128'hd4bf5d30_db135345_00000000_01010101;

    mix_columns_unit_if bus ();

    mix_columns_unit #(
        .NUM_COLS (4),
        .COL_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply, modulus 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product applied to every column of the state
    function automatic logic [127:0] ref_mix(input logic [127:0] din, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (inv) begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = din[127 - 32*c - 8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int j = 0; j < 4; j++) o = o ^ gmul(coef[(j - r) & 3], a[j]);
                res[127 - 32*c - 8*r -: 8] = o;
            end
        end
        return res;
    endfunction

    function automatic logic [129:0] hs(input logic ready, input logic busy);
        return 130'({ready, busy});
    endfunction

    task automatic set_inv(input logic inv);
`ifdef MC_INV_EN
        bus.inv_in = inv;
`else
        if (inv) $display("note: inverse request ignored in forward-only build");
`endif
    endtask

    // Called at a negedge; returns at a negedge one cycle after the ready pulse
    task automatic run_job(input string tag, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp, input bit disturb);
        bus.data_in  = din;
        bus.start_in = 1'b1;
        set_inv(inv);
        @(negedge clk);
        bus.start_in = 1'b0;
        check({tag, "_hs0"}, hs(bus.ready_out, bus.busy_out), hs(1'b0, 1'b1));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check({tag, "_hs"}, hs(bus.ready_out, bus.busy_out), hs(1'b0, 1'b1));
            end else begin
                check({tag, "_hs_done"}, hs(bus.ready_out, bus.busy_out), hs(1'b1, 1'b0));
                check({tag, "_data"}, 130'(bus.data_out), 130'(exp));
            end
            if (disturb && k == 1) begin
                bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
                bus.start_in = 1'b1;
                set_inv(~inv);
            end
            if (disturb && k == 2) bus.start_in = 1'b0;
        end
        @(negedge clk);
        check({tag, "_hs_after"}, hs(bus.ready_out, bus.busy_out), hs(1'b0, 1'b0));
        check({tag, "_hold"}, 130'(bus.data_out), 130'(exp));
    endtask

    initial begin
        logic [127:0] din;
        logic         inv;
        bus.start_in = 1'b0;
        bus.data_in  = '0;
        set_inv(1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold", {hs(bus.ready_out, bus.busy_out)} | 130'(bus.data_out), 130'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hs", hs(bus.ready_out, bus.busy_out), hs(1'b0, 1'b0));
            check("idle_data", 130'(bus.data_out), 130'(0));
        end

        run_job("fwd", c_FWD_IN, 1'b0, c_FWD_OUT, 1'b0);
        run_job("fips", c_FIPS_IN, 1'b0, c_FIPS_OUT, 1'b0);
        run_job("disturb", c_FWD_IN, 1'b0, c_FWD_OUT, 1'b1);

        // start held high: a new job every 5 clocks
        bus.data_in  = c_FIPS_IN;
        bus.start_in = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("cont_rdy", 130'(bus.ready_out), 130'(n % 5 == 4));
            if (n % 5 == 4) check("cont_data", 130'(bus.data_out), 130'(c_FIPS_OUT));
        end
        bus.start_in = 1'b0;
        @(negedge clk);
        check("cont_end", hs(bus.ready_out, bus.busy_out), hs(1'b0, 1'b0));

        // reset on the second CALC edge aborts the job
        bus.data_in  = c_FWD_IN;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rst", hs(bus.ready_out, bus.busy_out) | 130'(bus.data_out), 130'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_hs", hs(bus.ready_out, bus.busy_out), hs(1'b0, 1'b0));
            check("abort_data", 130'(bus.data_out), 130'(0));
        end
        run_job("post_abort", c_FWD_IN, 1'b0, c_FWD_OUT, 1'b0);

`ifdef MC_INV_EN
        run_job("inv", c_INV_IN, 1'b1, c_INV_OUT, 1'b0);
        run_job("inv_fwd", c_FWD_IN, 1'b0, c_FWD_OUT, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
`ifdef MC_INV_EN
            inv = 1'($urandom_range(0, 1));
`else
            inv = 1'b0;
`endif
            run_job("rand", din, inv, ref_mix(din, inv), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
